// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and default geometry for the convolution pipeline
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN,
      FLUSH
   } state_t;

   localparam int DEF_ROW_LENGTH = 1280;
   localparam int DEF_NUM_ROWS   = 960;
   localparam int DEF_WIDTH      = 12;

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - column/row raster position counter with wrap at frame end
module raster_counter #(
   parameter  int COLS = 4,
   parameter  int ROWS = 3,
   localparam int CW   = $clog2(COLS),
   localparam int RW   = $clog2(ROWS)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic          last_col,
   output logic          last_row
);

   assign last_col = (col == CW'(COLS - 1));
   assign last_row = (row == RW'(ROWS - 1));

   // clr restarts the raster; a simultaneous inc makes the current beat position (0,0)
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         col <= '0;
         row <= '0;
      end else if (clr) begin
         row <= '0;
         col <= inc ? CW'(1) : '0;
      end else if (inc) begin
         if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/conv_stream_aligner.sv
// rtl/conv_stream_aligner.sv - re-centres 3x3 convolution output onto the pixel grid,
// zeroes borders and completes each frame with trailing pixels.
module conv_stream_aligner
   import conv_pkg::*;
#(
   parameter int ROW_LENGTH = DEF_ROW_LENGTH,
   parameter int NUM_ROWS   = DEF_NUM_ROWS,
   parameter int WIDTH      = DEF_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   input  logic             i_sof,
   input  logic [WIDTH-1:0] i_conv,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_sof,
   output logic             o_eol,
   output logic             o_eof,
   output logic             o_busy,
   output logic             o_err
);

   localparam int CW = $clog2(ROW_LENGTH);
   localparam int RW = $clog2(NUM_ROWS);

   state_t           r_state;
   state_t           w_next;
   logic             w_start;
   logic             w_in_inc;
   logic             w_restart;
   logic             w_emit;
   logic             w_err_set;
   logic             w_border;

   logic [CW-1:0]    w_in_col;
   logic [RW-1:0]    w_in_row;
   logic             w_in_last_col;
   logic             w_in_last_row;
   logic [CW-1:0]    w_out_col;
   logic [RW-1:0]    w_out_row;
   logic             w_out_last_col;
   logic             w_out_last_row;

   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_sof;
   logic             r_eol;
   logic             r_eof;
   logic             r_busy;
   logic             r_err;

   assign w_start = i_valid & i_sof;

   raster_counter #(.COLS(ROW_LENGTH), .ROWS(NUM_ROWS)) u_in_pos (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .inc      (w_in_inc),
      .clr      (w_restart),
      .col      (w_in_col),
      .row      (w_in_row),
      .last_col (w_in_last_col),
      .last_row (w_in_last_row)
   );

   // Output pixels are produced in strict raster order, so a plain counter gives (y,x)
   raster_counter #(.COLS(ROW_LENGTH), .ROWS(NUM_ROWS)) u_out_pos (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .inc      (w_emit),
      .clr      (w_restart),
      .col      (w_out_col),
      .row      (w_out_row),
      .last_col (w_out_last_col),
      .last_row (w_out_last_row)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_in_inc  = 1'b0;
      w_restart = 1'b0;
      w_emit    = 1'b0;
      w_err_set = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_next   = PRIME;
               w_in_inc = 1'b1;
            end
         end
         PRIME, RUN: begin
            if (w_start) begin
               w_next    = PRIME;
               w_in_inc  = 1'b1;
               w_restart = 1'b1;
               w_err_set = 1'b1;
            end else if (i_valid) begin
               w_in_inc = 1'b1;
               if (r_state == PRIME) begin
                  if (w_in_last_col) w_next = RUN;
               end else begin
                  // column 0 of row 1 has nothing pending; later rows owe the previous trailing pixel
                  w_emit = (w_in_col != '0) || (w_in_row != RW'(1));
                  if (w_in_last_col && w_in_last_row) w_next = FLUSH;
               end
            end else if (w_in_col != '0) begin
               w_err_set = 1'b1;
            end
         end
         FLUSH: begin
            if (w_start) begin
               w_next    = PRIME;
               w_in_inc  = 1'b1;
               w_restart = 1'b1;
               w_err_set = 1'b1;
            end else begin
               w_emit    = 1'b1;
               w_err_set = i_valid;
               if (w_out_last_col && w_out_last_row) w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_border = (w_out_row == '0) || (w_out_col == '0) || w_out_last_row || w_out_last_col;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_sof   <= 1'b0;
         r_eol   <= 1'b0;
         r_eof   <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_data  <= (w_emit && (r_state == RUN) && !w_border) ? i_conv : '0;
         r_valid <= w_emit;
         r_sof   <= w_emit && (w_out_col == '0) && (w_out_row == '0);
         r_eol   <= w_emit && w_out_last_col;
         r_eof   <= w_emit && w_out_last_col && w_out_last_row;
         r_busy  <= (r_state != IDLE);
         r_err   <= r_err | w_err_set;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_sof   = r_sof;
   assign o_eol   = r_eol;
   assign o_eof   = r_eof;
   assign o_busy  = r_busy;
   assign o_err   = r_err;

endmodule

// File: tb/tb_conv_stream_aligner.sv
// tb/tb_conv_stream_aligner.sv - directed bench for conv_stream_aligner at 4x3 geometry
module tb_conv_stream_aligner;

   localparam int L = 4;
   localparam int R = 3;
   localparam int W = 12;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_valid;
   logic         i_sof;
   logic [W-1:0] i_conv;
   logic [W-1:0] o_data;
   logic         o_valid;
   logic         o_sof;
   logic         o_eol;
   logic         o_eof;
   logic         o_busy;
   logic         o_err;

   int           n_checks = 0;
   int           n_errors = 0;
   int           cyc = 0;
   int           eof_cyc;
   int           busy_low_cyc;
   int           t_last;
   logic [W+2:0] q[$];

   always #5 clk = ~clk;

   conv_stream_aligner #(.ROW_LENGTH(L), .NUM_ROWS(R), .WIDTH(W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (i_valid),
      .i_sof   (i_sof),
      .i_conv  (i_conv),
      .o_data  (o_data),
      .o_valid (o_valid),
      .o_sof   (o_sof),
      .o_eol   (o_eol),
      .o_eof   (o_eof),
      .o_busy  (o_busy),
      .o_err   (o_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input logic v, input logic s, input logic [W-1:0] d);
      i_valid = v;
      i_sof   = s;
      i_conv  = d;
      @(posedge clk);
      #1;
      cyc++;
      if (o_valid) q.push_back({o_data, o_sof, o_eol, o_eof});
      if (o_eof) eof_cyc = cyc;
      if ((o_sof | o_eol | o_eof) & ~o_valid) chk("marker_without_valid", 1, 0);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_sof   = 1'b0;
      i_conv  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Feeds one frame (conv = 100 + 4r + c), then idles until o_busy drops.
   task automatic run_frame(input int gap_after_row1, input bit drop_at_c2);
      q.delete();
      eof_cyc      = 0;
      busy_low_cyc = 0;
      for (int r = 0; r < R; r++) begin
         for (int c = 0; c < L; c++) begin
            if (drop_at_c2 && r == 0 && c == 2) step(1'b0, 1'b0, '0);
            if (r == R - 1 && c == L - 1) t_last = cyc;
            step(1'b1, (r == 0 && c == 0), W'(100 + 4 * r + c));
         end
         if (r == 1) repeat (gap_after_row1) step(1'b0, 1'b0, '0);
      end
      for (int k = 0; k < 20 && busy_low_cyc == 0; k++) begin
         step(1'b0, 1'b0, '0);
         if (!o_busy) busy_low_cyc = cyc;
      end
      if (busy_low_cyc == 0) chk("flush_timeout", 1, 0);
   endtask

   task automatic check_frame(input string tag);
      logic [W-1:0] ed;
      logic [2:0]   ef;
      chk({tag, "_count"}, q.size(), L * R);
      for (int k = 0; k < L * R && k < q.size(); k++) begin
         ed = (k == 5) ? W'(110) : (k == 6) ? W'(111) : '0;
         ef = {k == 0, (k % L) == L - 1, k == L * R - 1};
         chk($sformatf("%s_data%0d", tag, k), q[k][W+2:3], ed);
         chk($sformatf("%s_flags%0d", tag, k), q[k][2:0], ef);
      end
   endtask

   initial begin
      do_reset();
      chk("rst_data", o_data, 0);
      chk("rst_ctrl", {o_valid, o_sof, o_eol, o_eof, o_busy, o_err}, 0);

      run_frame(0, 1'b0);
      check_frame("frame_a");
      chk("eof_latency", eof_cyc - t_last, 6);
      chk("busy_low_latency", busy_low_cyc - t_last, 7);
      chk("err_a", o_err, 0);

      run_frame(3, 1'b0);
      check_frame("gap_b2b");
      chk("err_gap", o_err, 0);

      // Partial frame, then reset asynchronously mid-RUN
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < L && !(r == 1 && c == 3); c++)
            step(1'b1, (r == 0 && c == 0), W'(100 + 4 * r + c));
      chk("pre_rst_valid", o_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_data", o_data, 0);
      chk("async_rst_ctrl", {o_valid, o_sof, o_eol, o_eof, o_busy, o_err}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_frame(0, 1'b0);
      check_frame("after_rst");
      chk("err_after_rst", o_err, 0);

      run_frame(0, 1'b1);
      chk("err_drop", o_err, 1);
      run_frame(0, 1'b0);
      check_frame("after_drop");
      chk("err_sticky", o_err, 1);

      do_reset();
      chk("err_cleared", o_err, 0);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < L && !(r == 1 && c == 2); c++)
            step(1'b1, (r == 0 && c == 0), W'(100 + 4 * r + c));
      run_frame(0, 1'b0);
      check_frame("restart");
      chk("err_restart", o_err, 1);
      chk("restart_eof_latency", eof_cyc - t_last, 6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
